// File: rtl/prbs_gal_checker.sv
// Self-synchronising Galois PRBS checker: hunts for lock on the received stream,
// then free-runs and counts bit errors, dropping lock on excessive error density.
module prbs_gal_checker #(
  parameter int              LN          = 8,
  parameter logic [LN-1:0]   TAPS        = 8'hb4,
  parameter int              LOCK_CNT    = 16,
  parameter int              WIN_LEN     = 64,
  parameter int              LOSS_THRESH = 8,
  parameter int              CW          = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_bit,
  input  logic          i_clear,
  output logic          o_locked,
  output logic          o_err,
  output logic [CW-1:0] o_err_count,
  output logic [CW-1:0] o_bit_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t          state;
  logic [LN-1:0]   lfsr;
  logic [MW-1:0]   match_cnt;
  logic [WW-1:0]   win_cnt;
  logic [EW-1:0]   win_err;

  logic            pred;
  logic            mis;
  logic            stuck;
  logic            win_last;
  logic            count_en;
  logic [LN-1:0]   shifted;
  logic [LN-1:0]   hunt_next;
  logic [LN-1:0]   free_next;
  logic [MW-1:0]   match_inc;
  logic [EW-1:0]   win_err_sum;

  // win_err stays below LOSS_THRESH while locked, so the sum always fits in EW bits
  always_comb begin
    pred        = lfsr[0];
    mis         = i_bit ^ pred;
    stuck       = (lfsr == '0);
    shifted     = {1'b0, lfsr[LN-1:1]};
    hunt_next   = shifted ^ (i_bit ? TAPS : '0);
    free_next   = shifted ^ (pred ? TAPS : '0);
    match_inc   = match_cnt + 1'b1;
    win_err_sum = win_err + EW'(mis);
    win_last    = (win_cnt == WW'(WIN_LEN - 1));
    count_en    = i_ce && (state == LOCK) && !stuck;
  end

  assign o_locked = (state == LOCK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= HUNT;
      lfsr        <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_err       <= 1'b0;
      o_err_count <= '0;
      o_bit_count <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_ce) begin
        case (state)
          HUNT: begin
            lfsr <= hunt_next;
            if (mis) begin
              match_cnt <= '0;
            end else if (match_inc == MW'(LOCK_CNT)) begin
              state     <= LOCK;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_inc;
            end
          end
          LOCK: begin
            lfsr <= free_next;
            // an all-zero register can never predict a live stream again
            if (stuck) begin
              state     <= HUNT;
              match_cnt <= '0;
            end else begin
              o_err <= mis;
              if (win_err_sum >= EW'(LOSS_THRESH)) begin
                state     <= HUNT;
                match_cnt <= '0;
              end
              win_cnt <= win_last ? '0 : win_cnt + 1'b1;
              win_err <= win_last ? '0 : win_err_sum;
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (i_clear) begin
        o_bit_count <= '0;
        o_err_count <= '0;
      end else if (count_en) begin
        if (~&o_bit_count) o_bit_count <= o_bit_count + 1'b1;
        if (mis && ~&o_err_count) o_err_count <= o_err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_gal_checker.sv
// Bench for prbs_gal_checker: directed lock/error/window scenarios plus a random phase,
// all outputs compared every cycle against a reference-bit-history model.
module tb_prbs_gal_checker;

  localparam int         LN          = 8;
  localparam logic [7:0] TAPS        = 8'hb4;
  localparam int         LOCK_CNT    = 16;
  localparam int         WIN_LEN     = 64;
  localparam int         LOSS_THRESH = 8;
  localparam int         CW          = 10;
  localparam int         SAT         = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ce = 1'b0;
  logic          i_bit = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_locked;
  logic          o_err;
  logic [CW-1:0] o_err_count;
  logic [CW-1:0] o_bit_count;

  always #5 clk = ~clk;

  prbs_gal_checker #(
    .LN(LN), .TAPS(TAPS), .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN),
    .LOSS_THRESH(LOSS_THRESH), .CW(CW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_bit(i_bit), .i_clear(i_clear),
    .o_locked(o_locked), .o_err(o_err), .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] genState;

  // model: prediction is the tap-weighted parity of the last LN reference bits
  // (received bits while hunting, the model's own predictions while locked)
  bit mLocked, mErr;
  int mBits, mErrs, mRun, mLockSamples, mWinErr;
  bit qHist[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLocked = 0; mErr = 0; mBits = 0; mErrs = 0; mRun = 0; mLockSamples = 0; mWinErr = 0;
    qHist = {};
    for (int j = 0; j < LN; j++) qHist.push_back(1'b0);
  endtask

  task automatic pushRef(input bit v);
    qHist.push_front(v);
    void'(qHist.pop_back());
  endtask

  task automatic modelStep(input bit ce, input bit b, input bit clr);
    bit p, m, allZero, nextErr;
    nextErr = 0;
    if (ce) begin
      p = 0; allZero = 1;
      for (int j = 0; j < LN; j++) begin
        if (qHist[j]) allZero = 0;
        if (TAPS[j] && qHist[j]) p = ~p;
      end
      m = b ^ p;
      if (!mLocked) begin
        pushRef(b);
        if (m) mRun = 0;
        else begin
          mRun++;
          if (mRun == LOCK_CNT) begin
            mLocked = 1; mRun = 0; mLockSamples = 0; mWinErr = 0;
          end
        end
      end else begin
        pushRef(p);
        if (allZero) begin
          mLocked = 0; mRun = 0;
        end else begin
          if (!clr) begin
            if (mBits < SAT) mBits++;
            if (m && mErrs < SAT) mErrs++;
          end
          nextErr = m;
          if (mLockSamples % WIN_LEN == 0) mWinErr = 0;
          mWinErr += int'(m);
          mLockSamples++;
          if (mWinErr >= LOSS_THRESH) begin
            mLocked = 0; mRun = 0;
          end
        end
      end
    end
    if (clr) begin
      mBits = 0; mErrs = 0;
    end
    mErr = nextErr;
  endtask

  task automatic applyStimulus(input bit ce, input bit b, input bit clr, input bit rst);
    i_ce = ce; i_bit = b; i_clear = clr; i_reset = rst;
    @(posedge clk);
    if (rst) modelReset();
    else modelStep(ce, b, clr);
    #1;
    checkOutput("locked", 32'(o_locked), 32'(mLocked));
    checkOutput("err", 32'(o_err), 32'(mErr));
    checkOutput("bitCount", 32'(o_bit_count), mBits);
    checkOutput("errCount", 32'(o_err_count), mErrs);
  endtask

  task automatic genBit(output bit b);
    b = genState[0];
    genState = (genState >> 1) ^ (b ? TAPS : 8'h00);
  endtask

  task automatic sendGen(input bit flip, input bit clr);
    bit b;
    genBit(b);
    applyStimulus(1'b1, b ^ flip, clr, 1'b0);
  endtask

  task automatic alignWindow();
    int guard = 0;
    while ((mLockSamples % WIN_LEN) != 0 && guard < 2 * WIN_LEN) begin
      sendGen(1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic injectSpaced(input int n);
    for (int e = 0; e < n; e++) begin
      sendGen(1'b1, 1'b0);
      if (e < n - 1) repeat (3) sendGen(1'b0, 1'b0);
    end
  endtask

  int cnt, pulses, run, maxRun;
  bit ce, b;

  initial begin
    // reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("resetLocked", 32'(o_locked), 0);
    checkOutput("resetBits", 32'(o_bit_count), 0);

    // 1: clean acquisition from fill 8'h01; the first bit mismatches the empty register
    genState = 8'h01;
    cnt = 0;
    while (!o_locked && cnt < 100) begin sendGen(1'b0, 1'b0); cnt++; end
    checkOutput("t1LockPoint", cnt, LOCK_CNT + 1);
    repeat (1000) sendGen(1'b0, 1'b0);
    checkOutput("t1Bits1000", 32'(o_bit_count), 1000);
    checkOutput("t1Errs0", 32'(o_err_count), 0);

    // 2: single inverted bit
    sendGen(1'b1, 1'b0);
    checkOutput("t2ErrPulse", 32'(o_err), 1);
    checkOutput("t2ErrCount", 32'(o_err_count), 1);
    sendGen(1'b0, 1'b0);
    checkOutput("t2ErrOneCycle", 32'(o_err), 0);
    checkOutput("t2StillLocked", 32'(o_locked), 1);
    repeat (40) sendGen(1'b0, 1'b0);
    checkOutput("t2BitSat", 32'(o_bit_count), SAT);
    checkOutput("t2NoMoreErr", 32'(o_err_count), 1);

    // 3: eight errors in one window drop lock, then relock
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3Cleared", 32'(o_bit_count), 0);
    alignWindow();
    injectSpaced(8);
    checkOutput("t3Drop", 32'(o_locked), 0);
    checkOutput("t3Errs8", 32'(o_err_count), 8);
    checkOutput("t3LossErrPulse", 32'(o_err), 1);
    cnt = 0;
    while (!o_locked && cnt < 100) begin sendGen(1'b0, 1'b0); cnt++; end
    checkOutput("t3Relock", cnt, LOCK_CNT);
    checkOutput("t3ErrsKept", 32'(o_err_count), 8);

    // 4: seven errors in each of two adjacent windows keep lock
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    alignWindow();
    injectSpaced(7);
    alignWindow();
    injectSpaced(7);
    checkOutput("t4Held", 32'(o_locked), 1);
    checkOutput("t4Errs14", 32'(o_err_count), 14);

    // 5: random enable gaps, same bit sequence
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    genState = 8'h01;
    cnt = 0;
    for (int c = 0; c < 500 && !o_locked; c++) begin
      ce = $urandom_range(0, 1);
      if (ce) begin genBit(b); cnt++; end
      else b = $urandom_range(0, 1);
      applyStimulus(ce, b, 1'b0, 1'b0);
    end
    checkOutput("t5LockPoint", cnt, LOCK_CNT + 1);
    pulses = 0;
    repeat (300) begin
      ce = $urandom_range(0, 1);
      if (ce) begin genBit(b); pulses++; end
      else b = $urandom_range(0, 1);
      applyStimulus(ce, b, 1'b0, 1'b0);
    end
    checkOutput("t5BitsEqPulses", 32'(o_bit_count), pulses);

    // random phase: gaps, sparse errors and clears against the model
    repeat (1500) begin
      ce = ($urandom_range(0, 9) < 7);
      if (ce) begin
        genBit(b);
        b = b ^ ($urandom_range(0, 24) == 0);
      end else b = $urandom_range(0, 1);
      applyStimulus(ce, b, $urandom_range(0, 99) == 0, 1'b0);
    end

    // 6: clear coincident with an error, reset mid-lock, all-zero stream
    cnt = 0;
    while (!o_locked && cnt < 200) begin sendGen(1'b0, 1'b0); cnt++; end
    checkOutput("t6Locked", 32'(o_locked), 1);
    repeat (5) sendGen(1'b0, 1'b0);
    sendGen(1'b1, 1'b1);
    checkOutput("t6ClearBits", 32'(o_bit_count), 0);
    checkOutput("t6ClearErrs", 32'(o_err_count), 0);
    checkOutput("t6ClearErrPulse", 32'(o_err), 1);
    repeat (3) sendGen(1'b0, 1'b0);
    genBit(b);
    applyStimulus(1'b1, b, 1'b1, 1'b1);
    checkOutput("t6RstLocked", 32'(o_locked), 0);
    checkOutput("t6RstBits", 32'(o_bit_count), 0);
    run = 0; maxRun = 0;
    repeat (200) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (o_locked) run++; else run = 0;
      if (run > maxRun) maxRun = run;
    end
    checkOutput("t6ZeroNoHold", 32'(maxRun <= 1), 1);
    checkOutput("t6ZeroNoErrs", 32'(o_err_count), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
